// File: rtl/wavegen_pkg.sv
// Shared types and reset-configuration constants for the waveform generator.
//   wave_mode_t : waveform selection carried on the mode input
//   DEF_MODE    : waveform selected out of reset
//   DEF_STEP    : step field out of reset (effective increment = DEF_STEP+1)
package wavegen_pkg;

  typedef enum logic [1:0] {
    TRIANGLE = 2'd0,
    SAW_UP   = 2'd1,
    SAW_DOWN = 2'd2,
    SQUARE   = 2'd3
  } wave_mode_t;

  localparam wave_mode_t  DEF_MODE = TRIANGLE;
  localparam int unsigned DEF_STEP = 0;

endpackage

// File: rtl/waveform_generator_bounded_stepper.sv
// Combinational bounded step for the ramp modes.
// Ports:
//   cur_i    : current sample
//   step_i   : raw step field, increment s = step_i+1
//   lo_i     : lower bound
//   hi_i     : upper bound
//   dir_i    : 1 = step up, 0 = step down
//   strict_i : 1 = bound is hit only when overshot (sawtooth),
//              0 = bound is hit when reached or overshot (triangle)
//   next_o   : next sample, clamped to [lo_i, hi_i]
//   hit_hi_o : the upward step reaches/overshoots hi_i
//   hit_lo_o : the downward step reaches/overshoots lo_i
module bounded_stepper #(
  parameter int N      = 8,
  parameter int STEP_W = 4
) (
  input  logic [N-1:0]      cur_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [N-1:0]      lo_i,
  input  logic [N-1:0]      hi_i,
  input  logic              dir_i,
  input  logic              strict_i,
  output logic [N-1:0]      next_o,
  output logic              hit_hi_o,
  output logic              hit_lo_o
);

  localparam int AW = N + 1;

  logic [AW-1:0] s;
  logic [AW-1:0] cur_x;
  logic [AW-1:0] sum;
  logic [AW-1:0] lo_s;
  logic [N-1:0]  diff;

  // One extra bit so out+s and lo+s never wrap through 2^N.
  assign s     = AW'(step_i) + AW'(1);
  assign cur_x = AW'(cur_i);
  assign sum   = cur_x + s;
  assign lo_s  = AW'(lo_i) + s;
  // Only used when cur > lo+s, so the subtraction cannot go below zero.
  assign diff  = N'(cur_x - s);

  assign hit_hi_o = strict_i ? (sum > AW'(hi_i))  : (sum >= AW'(hi_i));
  assign hit_lo_o = strict_i ? (cur_x < lo_s)     : (cur_x <= lo_s);

  always_comb begin
    next_o = cur_i;
    if (dir_i) begin
      next_o = hit_hi_o ? hi_i : N'(sum);
    end else begin
      next_o = hit_lo_o ? lo_i : diff;
    end
  end

endmodule

// File: rtl/waveform_generator.sv
// Programmable triangle / sawtooth / square generator between lo and hi.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (resets config too)
//   ena      : advance enable; low holds all state
//   load     : latch mode/lo/hi/step and restart (rejected when lo > hi)
//   mode     : wave_mode_t selection
//   lo, hi   : unsigned bounds
//   step     : ramp increment-1, or SQUARE half-period-1 in enabled cycles
//   out      : registered sample
//   dir      : 1 rising / at hi, 0 falling / at lo
//   period   : one-cycle pulse at the start of each period
//   cfg_err  : one-cycle pulse when a load is rejected
module waveform_generator
  import wavegen_pkg::*;
#(
  parameter int N      = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              load,
  input  logic [1:0]        mode,
  input  logic [N-1:0]      lo,
  input  logic [N-1:0]      hi,
  input  logic [STEP_W-1:0] step,
  output logic [N-1:0]      out,
  output logic              dir,
  output logic              period,
  output logic              cfg_err
);

  localparam logic [N-1:0]      LO_RST   = '0;
  localparam logic [N-1:0]      HI_RST   = '1;
  localparam logic [STEP_W-1:0] STEP_RST = STEP_W'(DEF_STEP);

  wave_mode_t        mode_q, mode_d;
  logic [N-1:0]      lo_q, lo_d, hi_q, hi_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [N-1:0]      out_q, out_d;
  logic              dir_q, dir_d;
  logic              period_q, period_d;
  logic              cfg_err_q, cfg_err_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;

  logic              st_dir, st_strict, hit_hi, hit_lo;
  logic [N-1:0]      nxt;

  // Sawtooths always step one way and wrap only on overshoot;
  // the triangle follows dir and turns when a bound is reached.
  always_comb begin
    st_dir    = dir_q;
    st_strict = 1'b0;
    if (mode_q == SAW_UP) begin
      st_dir    = 1'b1;
      st_strict = 1'b1;
    end else if (mode_q == SAW_DOWN) begin
      st_dir    = 1'b0;
      st_strict = 1'b1;
    end
  end

  bounded_stepper #(.N(N), .STEP_W(STEP_W)) u_stepper (
    .cur_i    (out_q),
    .step_i   (step_q),
    .lo_i     (lo_q),
    .hi_i     (hi_q),
    .dir_i    (st_dir),
    .strict_i (st_strict),
    .next_o   (nxt),
    .hit_hi_o (hit_hi),
    .hit_lo_o (hit_lo)
  );

  always_comb begin
    mode_d    = mode_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    step_d    = step_q;
    out_d     = out_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    period_d  = 1'b0;
    cfg_err_d = 1'b0;
    if (load) begin
      if (lo <= hi) begin
        mode_d   = wave_mode_t'(mode);
        lo_d     = lo;
        hi_d     = hi;
        step_d   = step;
        cnt_d    = '0;
        period_d = 1'b1;
        if (wave_mode_t'(mode) == SAW_DOWN) begin
          out_d = hi;
          dir_d = 1'b0;
        end else begin
          out_d = lo;
          dir_d = 1'b1;
        end
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (ena) begin
      unique case (mode_q)
        TRIANGLE: begin
          out_d = nxt;
          if (dir_q && hit_hi) begin
            dir_d = 1'b0;
          end else if (!dir_q && hit_lo) begin
            dir_d    = 1'b1;
            period_d = 1'b1;
          end
        end
        SAW_UP: begin
          if (hit_hi) begin
            out_d    = lo_q;
            period_d = 1'b1;
          end else begin
            out_d = nxt;
          end
        end
        SAW_DOWN: begin
          if (hit_lo) begin
            out_d    = hi_q;
            period_d = 1'b1;
          end else begin
            out_d = nxt;
          end
        end
        SQUARE: begin
          if (cnt_q == step_q) begin
            cnt_d = '0;
            // With lo == hi the level cannot change, so only dir marks phases.
            if (lo_q == hi_q) begin
              dir_d    = ~dir_q;
              period_d = 1'b1;
            end else if (out_q == hi_q) begin
              out_d = lo_q;
              dir_d = 1'b0;
            end else begin
              out_d    = hi_q;
              dir_d    = 1'b1;
              period_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + STEP_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= DEF_MODE;
      lo_q      <= LO_RST;
      hi_q      <= HI_RST;
      step_q    <= STEP_RST;
      out_q     <= '0;
      dir_q     <= 1'b1;
      period_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      mode_q    <= mode_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      step_q    <= step_d;
      out_q     <= out_d;
      dir_q     <= dir_d;
      period_q  <= period_d;
      cfg_err_q <= cfg_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out     = out_q;
  assign dir     = dir_q;
  assign period  = period_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_waveform_generator.sv
module tb_waveform_generator;

  localparam int N      = 8;
  localparam int STEP_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              ena;
  logic              load;
  logic [1:0]        mode;
  logic [N-1:0]      lo;
  logic [N-1:0]      hi;
  logic [STEP_W-1:0] step;
  logic [N-1:0]      out;
  logic              dir;
  logic              period;
  logic              cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state, plain integers.
  int m_mode, m_lo, m_hi, m_step, m_out, m_dir, m_per, m_err, m_cnt;

  waveform_generator #(.N(N), .STEP_W(STEP_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .load    (load),
    .mode    (mode),
    .lo      (lo),
    .hi      (hi),
    .step    (step),
    .out     (out),
    .dir     (dir),
    .period  (period),
    .cfg_err (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_mode = 0; m_lo = 0; m_hi = (1 << N) - 1; m_step = 0;
    m_out = 0; m_dir = 1; m_per = 0; m_err = 0; m_cnt = 0;
  endtask

  // Applies one clock edge of the behaviour rules to the reference state.
  task automatic model_update();
    int s;
    if (rst) begin
      model_reset();
      return;
    end
    m_per = 0;
    m_err = 0;
    if (load) begin
      if (int'(lo) <= int'(hi)) begin
        m_mode = int'(mode); m_lo = int'(lo); m_hi = int'(hi); m_step = int'(step);
        m_cnt = 0; m_per = 1;
        if (m_mode == 2) begin m_out = m_hi; m_dir = 0; end
        else begin m_out = m_lo; m_dir = 1; end
      end else begin
        m_err = 1;
      end
    end else if (ena) begin
      s = m_step + 1;
      case (m_mode)
        0: begin
          if (m_dir == 1) begin
            if (m_out + s >= m_hi) begin m_out = m_hi; m_dir = 0; end
            else m_out = m_out + s;
          end else begin
            if (m_out <= m_lo + s) begin m_out = m_lo; m_dir = 1; m_per = 1; end
            else m_out = m_out - s;
          end
        end
        1: if (m_out + s > m_hi) begin m_out = m_lo; m_per = 1; end
           else m_out = m_out + s;
        2: if (m_out < m_lo + s) begin m_out = m_hi; m_per = 1; end
           else m_out = m_out - s;
        default: begin
          if (m_cnt == m_step) begin
            m_cnt = 0;
            if (m_lo == m_hi) begin m_dir = 1 - m_dir; m_per = 1; end
            else if (m_out == m_hi) begin m_out = m_lo; m_dir = 0; end
            else begin m_out = m_hi; m_dir = 1; m_per = 1; end
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
      endcase
    end
  endtask

  // Advance one clock; inputs were set before the edge, outputs sampled #1 after.
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b0; load = 1'b0; mode = 2'd0; lo = '0; hi = '0; step = '0;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
    n_checks++;
    if ({out, dir, period, cfg_err} !== {8'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: out=%0d dir=%0b period=%0b cfg_err=%0b, required 0/1/0/0",
               out, dir, period, cfg_err);
    end
  endtask

  task automatic test_default_triangle();
    int p, e_out, e_dir, e_per;
    ena = 1'b1;
    for (int k = 1; k <= 520; k++) begin
      cycle();
      p     = k % 510;
      e_out = (p <= 255) ? p : 510 - p;
      e_dir = (p < 255) ? 1 : 0;
      e_per = (p == 0) ? 1 : 0;
      n_checks++;
      if (int'(out) != e_out || int'(dir) != e_dir || int'(period) != e_per) begin
        n_fail++;
        $display("FAIL default_tri k=%0d: out=%0d dir=%0b per=%0b, required %0d/%0d/%0d",
                 k, out, dir, period, e_out, e_dir, e_per);
      end
    end
  endtask

  task automatic test_triangle_load();
    int e_out[10] = '{10, 13, 16, 19, 20, 17, 14, 11, 10, 13};
    int e_dir[10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    int e_per[10] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    load = 1'b1; mode = 2'd0; lo = 8'd10; hi = 8'd20; step = 4'd2; ena = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      // Config inputs are scrambled after the load and must be ignored.
      load = 1'b0; lo = 8'd0; hi = 8'd255; step = 4'd7; mode = 2'd3;
      n_checks++;
      if (int'(out) != e_out[i] || int'(dir) != e_dir[i] || int'(period) != e_per[i]) begin
        n_fail++;
        $display("FAIL tri_10_20 i=%0d: out=%0d dir=%0b per=%0b, required %0d/%0d/%0d",
                 i, out, dir, period, e_out[i], e_dir[i], e_per[i]);
      end
    end
  endtask

  task automatic test_saw();
    int up_out[5] = '{0, 4, 8, 0, 4};
    int dn_out[5] = '{9, 5, 1, 9, 5};
    int e_per[5]  = '{1, 0, 0, 1, 0};
    load = 1'b1; mode = 2'd1; lo = 8'd0; hi = 8'd9; step = 4'd3; ena = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      load = 1'b0;
      n_checks++;
      if (int'(out) != up_out[i] || dir !== 1'b1 || int'(period) != e_per[i]) begin
        n_fail++;
        $display("FAIL saw_up i=%0d: out=%0d dir=%0b per=%0b, required %0d/1/%0d",
                 i, out, dir, period, up_out[i], e_per[i]);
      end
    end
    load = 1'b1; mode = 2'd2;
    for (int i = 0; i < 5; i++) begin
      cycle();
      load = 1'b0;
      n_checks++;
      if (int'(out) != dn_out[i] || dir !== 1'b0 || int'(period) != e_per[i]) begin
        n_fail++;
        $display("FAIL saw_down i=%0d: out=%0d dir=%0b per=%0b, required %0d/0/%0d",
                 i, out, dir, period, dn_out[i], e_per[i]);
      end
    end
  endtask

  task automatic test_square_ena();
    int e_out[10] = '{5, 5, 5, 200, 200, 200, 5, 5, 5, 200};
    int e_per[10] = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    int hi_run;
    bit done;
    load = 1'b1; mode = 2'd3; lo = 8'd5; hi = 8'd200; step = 4'd2; ena = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      load = 1'b0;
      n_checks++;
      if (int'(out) != e_out[i] || int'(period) != e_per[i]) begin
        n_fail++;
        $display("FAIL square i=%0d: out=%0d per=%0b, required %0d/%0d",
                 i, out, period, e_out[i], e_per[i]);
      end
    end
    // out is now 200 at the start of a half-period; freeze for 2 cycles mid-way.
    hi_run = 1;
    done   = 1'b0;
    for (int j = 0; j < 20 && !done; j++) begin
      ena = (j == 1 || j == 2) ? 1'b0 : 1'b1;
      cycle();
      if (out == 8'd200) hi_run++;
      else done = 1'b1;
    end
    ena = 1'b1;
    n_checks++;
    if (!done || hi_run != 5 || out !== 8'd5) begin
      n_fail++;
      $display("FAIL square_stretch: high samples=%0d out=%0d ended=%0b, required 5/5/1",
               hi_run, out, done);
    end
  endtask

  task automatic test_cfg_err();
    logic [N-1:0] prev;
    prev = out;
    load = 1'b1; mode = 2'd1; lo = 8'd50; hi = 8'd40; ena = 1'b1;
    cycle();
    load = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b1 || out !== prev || period !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_err_pulse: cfg_err=%0b out=%0d per=%0b, required 1/%0d/0",
               cfg_err, out, period, prev);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if (cfg_err !== 1'b0 || int'(out) != m_out || int'(period) != m_per) begin
        n_fail++;
        $display("FAIL cfg_err_after i=%0d: cfg_err=%0b out=%0d per=%0b, required 0/%0d/%0d",
                 i, cfg_err, out, period, m_out, m_per);
      end
    end
    load = 1'b1; mode = 2'd0; lo = 8'd33; hi = 8'd99; step = 4'd0; ena = 1'b1;
    cycle();
    load = 1'b0;
    n_checks++;
    if (out !== 8'd33 || dir !== 1'b1 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL load_over_ena: out=%0d dir=%0b cfg_err=%0b, required 33/1/0",
               out, dir, cfg_err);
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 600; i++) begin
      ena  = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 29) == 0);
      mode = 2'($urandom_range(0, 3));
      step = STEP_W'($urandom_range(0, 15));
      lo   = N'($urandom_range(0, 255));
      r    = $urandom_range(0, 3);
      if (r == 0)      hi = lo;
      else if (r == 1) hi = N'($urandom_range(0, 255));
      else             hi = N'((int'(lo) + $urandom_range(0, 40) > 255) ? 255 : int'(lo) + $urandom_range(0, 40));
      cycle();
      n_checks++;
      if (int'(out) != m_out || int'(dir) != m_dir || int'(period) != m_per || int'(cfg_err) != m_err) begin
        n_fail++;
        $display("FAIL random i=%0d: out=%0d dir=%0b per=%0b err=%0b, required %0d/%0d/%0d/%0d",
                 i, out, dir, period, cfg_err, m_out, m_dir, m_per, m_err);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_async_reset();
    int e_out;
    load = 1'b1; mode = 2'd2; lo = 8'd0; hi = 8'd255; step = 4'd5; ena = 1'b1;
    cycle();
    load = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out !== 8'd0 || dir !== 1'b1 || period !== 1'b0 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: out=%0d dir=%0b per=%0b err=%0b, required 0/1/0/0",
               out, dir, period, cfg_err);
    end
    cycle();
    rst = 1'b0;
    model_reset();
    // Default 0..255 triangle with step 1 must resume.
    for (int k = 1; k <= 300; k++) begin
      cycle();
      e_out = (k <= 255) ? k : 510 - k;
      n_checks++;
      if (int'(out) != e_out || int'(out) != m_out) begin
        n_fail++;
        $display("FAIL post_reset_tri k=%0d: out=%0d, required %0d", k, out, e_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_triangle();
    test_triangle_load();
    test_saw();
    test_square_ena();
    test_cfg_err();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/waveform_generator.md
Name: waveform_generator

Overview:
Parametrised successor to the fixed 8-bit triangle counter. Produces triangle, sawtooth-up, sawtooth-down or square sequences between programmable lower and upper bounds, with a programmable step or half-period. Advances only on cycles where ena is high. Sits in the stimulus/PWM-reference path, feeding DAC/PWM comparators and the LED demo blocks.

Parameters:
N, 8, output and bound width in bits (N >= 2)
STEP_W, 4, width of the step field; the effective step is step+1, range 1..2^STEP_W

Ports:
clk  input  1  clock
rst  input  1  reset: asynchronous, active-high
ena  input  1  advance enable; when low, out, dir and the internal counter hold
load  input  1  latch mode/lo/hi/step into the config registers and restart the waveform
mode  input  2  wave_mode_t: TRIANGLE=0, SAW_UP=1, SAW_DOWN=2, SQUARE=3
lo  input  N  lower bound, unsigned
hi  input  N  upper bound, unsigned
step  input  STEP_W  ramp modes: increment = step+1; SQUARE: half-period = step+1 enabled cycles
out  output  N  current sample, registered
dir  output  1  1 = rising, 0 = falling (SQUARE: 1 = at hi)
period  output  1  one-cycle pulse marking the start of each new period
cfg_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset values: out=0, dir=1, period=0, cfg_err=0, half-period counter=0; config mode=TRIANGLE, lo=0, hi=2^N-1, step=0 (increment 1). With this reset config the block reproduces the original 0..2^N-1..0 triangle.
- All outputs are registered and update on the posedge clk after the causing input. Latency is 1 cycle.
- Priority: rst > load > ena.
- Load, lo <= hi:
  - Config registers take the inputs and the counter clears.
  - TRIANGLE, SAW_UP, SQUARE: out=lo, dir=1.
  - SAW_DOWN: out=hi, dir=0.
  - period=1 on the following cycle.
- Load, lo > hi: config and out are unchanged, cfg_err=1 for one cycle, period=0.
- Arithmetic: compute in N+1 bits with s = step+1. No wrap-around through 0 or 2^N is ever visible on out.
- TRIANGLE, dir=1: if out+s >= hi then out=hi and dir=0; else out=out+s.
- TRIANGLE, dir=0: if out <= lo+s then out=lo, dir=1, period=1; else out=out-s.
- Turning points are clamped to the bounds, so hi and lo each appear for exactly one enabled cycle per period.
- SAW_UP: if out+s > hi then out=lo and period=1; else out=out+s. dir stays 1.
- SAW_DOWN: if out < lo+s then out=hi and period=1; else out=out-s. dir stays 0.
- SQUARE: counter increments on each enabled cycle.
  - When counter == step: counter=0, out toggles between lo and hi, dir follows (1 at hi).
  - period=1 on each lo->hi transition.
- lo == hi:
  - Ramp modes hold out=lo.
  - TRIANGLE: dir toggles each enabled cycle; period pulses on every down->up turn.
  - SAW modes: period pulses every enabled cycle.
  - SQUARE: out stays constant; period pulses each half-period count while dir toggles.
- ena low: all state holds and period=0. A pending turn is taken on the next enabled cycle.
- Config inputs are ignored except when load is high; changing them mid-run has no effect.
- rst asserted mid-operation returns everything, including config, to the reset values above, asynchronously.

Decomposition:
- Package wavegen_pkg holds:
  - typedef enum logic [1:0] wave_mode_t {TRIANGLE, SAW_UP, SAW_DOWN, SQUARE}
  - the reset-config constants (default mode and default step)
- Bound-dependent defaults (lo=0, hi=all ones) are derived from N inside the module.
- One sub-module is natural: bounded_stepper (N, STEP_W). It is combinational and, from out, s, lo, hi and dir, returns the next value plus hit_hi and hit_lo flags. The FSM and config registers stay in waveform_generator.
- No other sub-modules.

Test Plan:
- Reset only, ena=1, N=8 -> out counts 0,1,...,255,254,...,0,1. dir falls on the cycle out becomes 255. period pulses when out returns to 0. Full period is 510 cycles.
- Load TRIANGLE lo=10 hi=20 step=2 (s=3) -> out: 10,13,16,19,20,17,14,11,10,13. period pulses on the second 10. dir low from 20 through 11.
- Load SAW_UP lo=0 hi=9 step=3 (s=4) -> out: 0,4,8,0,4. period is 1 on each return to 0. Then load SAW_DOWN with the same bounds and step -> 9,5,1,9.
- Load SQUARE lo=5 hi=200 step=2 -> out holds 5 for 3 enabled cycles, then 200 for 3, repeating. Toggle ena low for 2 cycles mid half-period -> out and the counter freeze, and the half-period stretches by exactly 2.
- Load lo=50 hi=40 -> cfg_err pulses 1 cycle; out and the waveform continue unchanged. Load with load and ena both high -> load wins and out equals the new lo on the next cycle.
- Assert rst asynchronously mid-ramp in SAW_DOWN -> out=0, dir=1, config back to reset defaults. On release, the default 0..255 triangle resumes.
